// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control FSM for a single-issue RV32I core: fetch/decode/exec/mem/wb
// sequencing, datapath strobes, trap on unknown opcodes and a retired-instruction counter.
module core_ctrl_fsm #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [1:0]           dmem_size,
    input  logic                 dmem_ready,
    input  logic                 br_taken,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic [1:0]           pc_sel,
    output logic                 rd_en1,
    output logic                 rd_en2,
    output logic                 wr_en,
    output logic [3:0]           alu_func,
    output logic                 alu_src_a,
    output logic                 alu_src_b,
    output logic [1:0]           wb_sel,
    output logic                 retire,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
    typedef enum logic [3:0] {C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
                              C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} class_e;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = INSTRET_W'(1);

    function automatic class_e op_class(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_IALU;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    state_e                 state_q, state_d;
    logic [31:0]            ir_q, ir_d;
    class_e                 cls_q, cls_d;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [1:0]             dmem_size_q, dmem_size_d, wb_sel_q, wb_sel_d;
    logic                   rd_en1_q, rd_en1_d, rd_en2_q, rd_en2_d, wr_en_q, wr_en_d;
    logic [3:0]             alu_func_q, alu_func_d;
    logic                   alu_src_a_q, alu_src_a_d, alu_src_b_q, alu_src_b_d;
    logic                   illegal_q, illegal_d;
    logic                   ir_en_c, pc_en_c;
    logic [1:0]             pc_sel_c;

    assign cls_q = op_class(ir_q[6:0]);

    // Registered outputs are computed for the state being entered, so they are
    // valid for the whole of that state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_FETCH:  if (imem_ready) begin
                          ir_d    = imem_rdata;
                          state_d = S_DECODE;
                      end
            S_DECODE: state_d = (cls_q == C_BAD) ? S_TRAP : S_EXEC;
            S_EXEC:   case (cls_q)
                          C_LOAD, C_STORE: state_d = S_MEM;
                          C_BRANCH:        state_d = S_FETCH;
                          default:         state_d = S_WB;
                      endcase
            S_MEM:    if (dmem_ready) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase

        cls_d       = op_class(ir_d[6:0]);
        imem_req_d  = (state_d == S_FETCH);
        illegal_d   = (state_d == S_TRAP);
        dmem_req_d  = 1'b0;
        dmem_we_d   = 1'b0;
        dmem_size_d = '0;
        rd_en1_d    = 1'b0;
        rd_en2_d    = 1'b0;
        wr_en_d     = 1'b0;
        alu_func_d  = '0;
        alu_src_a_d = 1'b0;
        alu_src_b_d = 1'b0;
        wb_sel_d    = '0;
        case (state_d)
            S_DECODE: case (cls_d)
                          C_R, C_STORE, C_BRANCH: begin rd_en1_d = 1'b1; rd_en2_d = 1'b1; end
                          C_IALU, C_LOAD, C_JALR: rd_en1_d = 1'b1;
                          default: ;
                      endcase
            S_EXEC:   case (cls_d)
                          C_R:      alu_func_d = alu_code(ir_d[14:12], ir_d[30]);
                          C_IALU:   begin
                                        alu_func_d  = alu_code(ir_d[14:12], (ir_d[14:12] == 3'b101) && ir_d[30]);
                                        alu_src_b_d = 1'b1;
                                    end
                          C_LOAD, C_STORE, C_JALR: alu_src_b_d = 1'b1;
                          C_AUIPC:  begin alu_src_a_d = 1'b1; alu_src_b_d = 1'b1; end
                          C_BRANCH: alu_func_d = 4'd1;
                          default: ;
                      endcase
            S_MEM:    begin
                          dmem_req_d  = 1'b1;
                          dmem_we_d   = (cls_d == C_STORE);
                          dmem_size_d = ir_d[13:12];
                      end
            S_WB:     begin
                          wr_en_d = (ir_d[11:7] != 5'd0);
                          case (cls_d)
                              C_LOAD:        wb_sel_d = 2'd1;
                              C_JAL, C_JALR: wb_sel_d = 2'd2;
                              C_LUI:         wb_sel_d = 2'd3;
                              default:       wb_sel_d = 2'd0;
                          endcase
                      end
            default: ;
        endcase
    end

    // Strobes that depend on the handshake or branch outcome of the current cycle.
    always_comb begin
        ir_en_c  = (state_q == S_FETCH) && imem_ready;
        pc_en_c  = 1'b0;
        pc_sel_c = 2'd0;
        case (state_q)
            S_EXEC: if (cls_q == C_BRANCH) begin
                        pc_en_c  = 1'b1;
                        pc_sel_c = br_taken ? 2'd1 : 2'd0;
                    end
            S_MEM:  pc_en_c = (cls_q == C_STORE) && dmem_ready;
            S_WB:   begin
                        pc_en_c  = 1'b1;
                        pc_sel_c = (cls_q == C_JAL) ? 2'd1 : (cls_q == C_JALR) ? 2'd2 : 2'd0;
                    end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            instret_q   <= '0;
            imem_req_q  <= 1'b1;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_size_q <= '0;
            rd_en1_q    <= 1'b0;
            rd_en2_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            alu_func_q  <= '0;
            alu_src_a_q <= 1'b0;
            alu_src_b_q <= 1'b0;
            wb_sel_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            dmem_size_q <= dmem_size_d;
            rd_en1_q    <= rd_en1_d;
            rd_en2_q    <= rd_en2_d;
            wr_en_q     <= wr_en_d;
            alu_func_q  <= alu_func_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
            wb_sel_q    <= wb_sel_d;
            illegal_q   <= illegal_d;
            if (pc_en_c) instret_q <= instret_q + INSTRET_ONE;
        end
    end

    // Holding reset low silences every output at once, so a pending request
    // or completing access cannot leak out before the reset edge.
    assign imem_req  = reset & imem_req_q;
    assign dmem_req  = reset & dmem_req_q;
    assign dmem_we   = reset & dmem_we_q;
    assign dmem_size = reset ? dmem_size_q : '0;
    assign ir_en     = reset & ir_en_c;
    assign pc_en     = reset & pc_en_c;
    assign retire    = reset & pc_en_c;
    assign pc_sel    = reset ? pc_sel_c : '0;
    assign rd_en1    = reset & rd_en1_q;
    assign rd_en2    = reset & rd_en2_q;
    assign wr_en     = reset & wr_en_q;
    assign alu_func  = reset ? alu_func_q : '0;
    assign alu_src_a = reset & alu_src_a_q;
    assign alu_src_b = reset & alu_src_b_q;
    assign wb_sel    = reset ? wb_sel_q : '0;
    assign illegal   = reset & illegal_q;
    assign instret   = reset ? instret_q : '0;

endmodule
